// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
package fifo_arb_pkg;

  typedef enum logic {
    ARB_IDLE  = 1'b0,
    ARB_BURST = 1'b1
  } arb_state_e;

  // Width of a requester index; never narrower than one bit.
  function automatic int idx_width(input int n_req);
    return (n_req <= 2) ? 1 : $clog2(n_req);
  endfunction

  // Width of a counter that must hold 0..max_burst.
  function automatic int cnt_width(input int max_burst);
    return $clog2(max_burst + 1);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin picker: first asserted request at or after ptr_i, wrapping.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ = 4,
  localparam int IDX_W = idx_width(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             any_o,
  output logic [IDX_W-1:0] winner_o
);

  logic [IDX_W-1:0] idx;

  // Scan offsets from farthest to nearest so the nearest hit is the last one written.
  always_comb begin
    any_o    = |req_i;
    winner_o = '0;
    idx      = '0;
    for (int off = N_REQ - 1; off >= 0; off--) begin
      idx = IDX_W'((int'(ptr_i) + off) % N_REQ);
      if (req_i[idx]) begin
        winner_o = idx;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded sharing of one FIFO write port among N_REQ producers.
// A full FIFO stalls the current owner; nothing is ever dropped.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int N_REQ      = 4,
  parameter  int DATA_WIDTH = 8,
  parameter  int MAX_BURST  = 4,
  localparam int IDX_W      = idx_width(N_REQ),
  localparam int CNT_W      = cnt_width(MAX_BURST)
) (
  input  logic                        clk,
  input  logic                        res_n,
  input  logic [N_REQ-1:0]            req_i,
  input  logic [N_REQ*DATA_WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            grant_o,
  output logic [DATA_WIDTH-1:0]       fifo_data_o,
  output logic                        fifo_enable_o,
  input  logic                        fifo_busy_flag,
  output logic [IDX_W-1:0]            owner_o,
  output logic                        arb_active_o
);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic             pick_any;
  logic [IDX_W-1:0] pick_idx;
  logic [IDX_W-1:0] owner_next_ptr;
  logic             owner_req;
  logic             write;

  logic [DATA_WIDTH-1:0] words [N_REQ];

  for (genvar k = 0; k < N_REQ; k++) begin : g_words
    assign words[k] = req_data_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req_i    (req_i),
    .ptr_i    (rr_ptr_q),
    .any_o    (pick_any),
    .winner_o (pick_idx)
  );

  // Reset gates the write so no word is lost while the arbiter is being cleared.
  assign owner_req      = req_i[owner_q];
  assign write          = (state_q == ARB_BURST) & owner_req & ~fifo_busy_flag & res_n;
  assign owner_next_ptr = (owner_q == IDX_W'(N_REQ - 1)) ? '0 : owner_q + 1'b1;

  // Next-state: grant in IDLE, count/stall/release in BURST.
  always_comb begin
    state_d     = state_q;
    grant_d     = grant_q;
    owner_d     = owner_q;
    rr_ptr_d    = rr_ptr_q;
    burst_cnt_d = burst_cnt_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (pick_any) begin
          state_d     = ARB_BURST;
          grant_d     = N_REQ'(1) << pick_idx;
          owner_d     = pick_idx;
          burst_cnt_d = '0;
        end
      end
      ARB_BURST: begin
        if (!owner_req) begin
          // Owner ran dry: release even if the FIFO is also full.
          state_d  = ARB_IDLE;
          grant_d  = '0;
          rr_ptr_d = owner_next_ptr;
        end else if (write) begin
          burst_cnt_d = burst_cnt_q + 1'b1;
          if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
            state_d  = ARB_IDLE;
            grant_d  = '0;
            rr_ptr_d = owner_next_ptr;
          end
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Arbiter state registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!res_n) begin
      state_q     <= ARB_IDLE;
      grant_q     <= '0;
      owner_q     <= '0;
      rr_ptr_q    <= '0;
      burst_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      owner_q     <= owner_d;
      rr_ptr_q    <= rr_ptr_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  assign grant_o       = grant_q;
  assign owner_o       = owner_q;
  assign arb_active_o  = (state_q == ARB_BURST);
  assign fifo_enable_o = write;
  assign fifo_data_o   = (|grant_q) ? words[owner_q] : '0;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: producer models feed words, a scoreboard checks every FIFO write.
module tb_fifo_wr_arbiter;

  typedef struct packed {
    logic [1:0] o;
    logic [7:0] d;
  } exp_t;

  logic        clk;
  logic        res_n;
  logic [3:0]  req_i;
  logic [31:0] req_data_i;
  logic [3:0]  grant_o;
  logic [7:0]  fifo_data_o;
  logic        fifo_enable_o;
  logic        fifo_busy_flag;
  logic [1:0]  owner_o;
  logic        arb_active_o;

  logic [7:0]  buf_mem [4][64];
  logic [5:0]  head [4];
  logic [5:0]  tail [4];
  logic [3:0]  cons_w;
  exp_t        exp_q [$];
  logic        mon_en;
  int          n_cmp;
  int          n_mis;

  fifo_wr_arbiter #(.N_REQ(4), .DATA_WIDTH(8), .MAX_BURST(4)) dut (
    .clk            (clk),
    .res_n          (res_n),
    .req_i          (req_i),
    .req_data_i     (req_data_i),
    .grant_o        (grant_o),
    .fifo_data_o    (fifo_data_o),
    .fifo_enable_o  (fifo_enable_o),
    .fifo_busy_flag (fifo_busy_flag),
    .owner_o        (owner_o),
    .arb_active_o   (arb_active_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Producers: request while the word buffer is non-empty, present the head word.
  always_comb begin
    req_i      = 4'b0;
    req_data_i = 32'b0;
    for (int k = 0; k < 4; k++) begin
      req_i[k] = (head[k] != tail[k]);
      if (head[k] != tail[k]) req_data_i[k*8 +: 8] = buf_mem[k][head[k]];
    end
  end

  // Producers: a word is consumed on a cycle with grant and enable.
  always @(posedge clk) begin
    cons_w <= fifo_enable_o ? grant_o : 4'b0;
    #1;
    for (int k = 0; k < 4; k++)
      if (cons_w[k] && (head[k] != tail[k])) head[k] <= head[k] + 6'd1;
  end

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_mis++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endfunction

  // Monitor: every write is popped against the scoreboard; invariants checked each cycle.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      chk("grant_onehot0", 32'($onehot0(grant_o)), 32'd1);
      if (fifo_enable_o) begin
        chk("en_not_busy", 32'(fifo_busy_flag), 32'd0);
        chk("en_granted_req", 32'(|(grant_o & req_i)), 32'd1);
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_mis++;
          $display("FAIL unexpected_write: got owner=%0d data=%0h, required no write", owner_o, fifo_data_o);
        end else begin
          e = exp_q.pop_front();
          chk("wr_owner", 32'(owner_o), 32'(e.o));
          chk("wr_grant", 32'(grant_o), 32'(4'b0001 << e.o));
          chk("wr_data", 32'(fifo_data_o), 32'(e.d));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic load(input logic [1:0] k, input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      buf_mem[k][tail[k]] = base + 8'(i);
      tail[k] = tail[k] + 6'd1;
    end
  endtask

  task automatic expect_words(input logic [1:0] o, input logic [7:0] base, input int n);
    exp_t e;
    for (int i = 0; i < n; i++) begin
      e.o = o;
      e.d = base + 8'(i);
      exp_q.push_back(e);
    end
  endtask

  initial begin
    logic [3:0] g2 [5];
    g2 = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    n_cmp = 0;
    n_mis = 0;
    mon_en = 1'b0;
    res_n = 1'b0;
    fifo_busy_flag = 1'b0;
    for (int k = 0; k < 4; k++) begin
      head[k] = '0;
      tail[k] = '0;
    end

    // Reset state
    repeat (2) step();
    chk("rst_grant", 32'(grant_o), 32'h0);
    chk("rst_owner", 32'(owner_o), 32'h0);
    chk("rst_active", 32'(arb_active_o), 32'h0);
    chk("rst_enable", 32'(fifo_enable_o), 32'h0);
    res_n = 1'b1;
    mon_en = 1'b1;
    step();

    // All four requesting: order 0,1,2,3,0, four words each, one idle cycle between
    load(2'd0, 8'h10, 8);
    load(2'd1, 8'h20, 4);
    load(2'd2, 8'h30, 4);
    load(2'd3, 8'h40, 4);
    expect_words(2'd0, 8'h10, 4);
    expect_words(2'd1, 8'h20, 4);
    expect_words(2'd2, 8'h30, 4);
    expect_words(2'd3, 8'h40, 4);
    expect_words(2'd0, 8'h14, 4);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rr_grant", 32'(grant_o), 32'(g2[i]));
      chk("rr_active", 32'(arb_active_o), 32'h1);
      repeat (4) step();
      chk("rr_bubble", 32'(grant_o), 32'h0);
    end

    // Single requester 2, three words, then drops
    load(2'd2, 8'hA1, 3);
    expect_words(2'd2, 8'hA1, 3);
    step();
    chk("single_grant", 32'(grant_o), 32'b0100);
    chk("single_owner", 32'(owner_o), 32'd2);
    repeat (3) step();
    chk("single_held", 32'(grant_o), 32'b0100);
    chk("single_noen", 32'(fifo_enable_o), 32'h0);
    step();
    chk("single_release", 32'(grant_o), 32'h0);

    // Pointer now at 3: requests 3 and 0 -> 3 first, then 0 after a bubble
    load(2'd3, 8'h51, 2);
    load(2'd0, 8'h61, 2);
    expect_words(2'd3, 8'h51, 2);
    expect_words(2'd0, 8'h61, 2);
    step();
    chk("wrap_first", 32'(grant_o), 32'b1000);
    repeat (3) step();
    chk("wrap_bubble", 32'(grant_o), 32'h0);
    step();
    chk("wrap_second", 32'(grant_o), 32'b0001);
    repeat (3) step();
    chk("wrap_release", 32'(grant_o), 32'h0);

    // FIFO full for three cycles after the second word
    load(2'd0, 8'h71, 4);
    expect_words(2'd0, 8'h71, 4);
    step();
    chk("busy_grant", 32'(grant_o), 32'b0001);
    repeat (2) step();
    fifo_busy_flag = 1'b1;
    #1;
    chk("busy_noen0", 32'(fifo_enable_o), 32'h0);
    repeat (2) begin
      step();
      chk("busy_noen", 32'(fifo_enable_o), 32'h0);
      chk("busy_held", 32'(grant_o), 32'b0001);
    end
    step();
    fifo_busy_flag = 1'b0;
    step();
    chk("busy_resume", 32'(grant_o), 32'b0001);
    step();
    chk("busy_release", 32'(grant_o), 32'h0);

    // Reset in the middle of a burst
    load(2'd0, 8'h81, 6);
    expect_words(2'd0, 8'h81, 2);
    step();
    chk("mrst_grant", 32'(grant_o), 32'b0001);
    repeat (2) step();
    res_n = 1'b0;
    #1;
    chk("mrst_noen", 32'(fifo_enable_o), 32'h0);
    step();
    chk("mrst_grant0", 32'(grant_o), 32'h0);
    chk("mrst_idle", 32'(arb_active_o), 32'h0);
    chk("mrst_owner0", 32'(owner_o), 32'h0);
    tail[0] = head[0];
    load(2'd1, 8'h91, 2);
    expect_words(2'd1, 8'h91, 2);
    res_n = 1'b1;
    step();
    chk("post_rst_grant", 32'(grant_o), 32'b0010);
    chk("post_rst_owner", 32'(owner_o), 32'd1);

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 20 && exp_q.size() != 0; i++) step();
    chk("drain_left", 32'(exp_q.size()), 32'd0);
    repeat (3) step();
    chk("final_idle", 32'(grant_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
